// File: rtl/vend_ctrl_n.sv
// vend_ctrl_n: parametrised vending controller.
// Credit is kept in half-yuan units. Coins are accepted up to a ceiling, a
// product is released over a take handshake, and change goes back one coin
// per ready cycle.
module vend_ctrl_n #(
  parameter int N_ITEMS = 4,
  parameter int SUM_W   = 7,
  parameter int SUM_MAX = 80,
  parameter logic [N_ITEMS*SUM_W-1:0] PRICES = {7'd14, 7'd6, 7'd10, 7'd5},
  parameter int IDX_W   = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               power,
  input  logic               insert,
  input  logic [1:0]         coin_val,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic               cancel,
  input  logic               take_ack,
  input  logic               chg_ready,
  output logic               hold_ind,
  output logic [N_ITEMS-1:0] item_avail,
  output logic               vend_valid,
  output logic [IDX_W-1:0]   vend_idx,
  output logic               chg_pulse,
  output logic               chg_type,
  output logic               coin_reject,
  output logic               sel_reject,
  output logic [SUM_W-1:0]   coin_sum
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_REFUND} state_e;

  localparam logic [SUM_W:0] SUM_MAX_L = (SUM_W+1)'(SUM_MAX);
  localparam logic [IDX_W:0] N_ITEMS_L = (IDX_W+1)'(N_ITEMS);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               vend_valid_q, vend_valid_d;
  logic [IDX_W-1:0]   vend_idx_q, vend_idx_d;
  logic               pend_q, pend_d;
  logic               chg_pulse_q, chg_pulse_d;
  logic               chg_type_q, chg_type_d;
  logic               coin_rej_q, coin_rej_d;
  logic               sel_rej_q, sel_rej_d;

  logic [SUM_W-1:0]   price [N_ITEMS];
  logic [SUM_W-1:0]   sel_price;
  logic [SUM_W:0]     coin_v;
  logic [SUM_W:0]     sum_add;
  logic               coin_ok;
  logic               accepting;
  logic               sel_ok;

  // unpack the price table; an item is available only while taking credit
  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    assign price[i]      = PRICES[i*SUM_W +: SUM_W];
    assign item_avail[i] = (state_q == S_CREDIT) && (sum_q >= price[i]);
  end

  // coin decode and ceiling check, done one bit wider so the sum cannot wrap
  always_comb begin
    coin_v = '0;
    case (coin_val)
      2'b01:   coin_v = (SUM_W+1)'(2);
      2'b10:   coin_v = (SUM_W+1)'(20);
      2'b11:   coin_v = (SUM_W+1)'(1);
      default: coin_v = '0;
    endcase
    sum_add   = {1'b0, sum_q} + coin_v;
    coin_ok   = (coin_val != 2'b00) && (sum_add <= SUM_MAX_L);
    accepting = power && !cancel &&
                ((state_q == S_IDLE) || (state_q == S_CREDIT));
  end

  // price of the selected item; out-of-range indices never match
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (sel_idx == i[IDX_W-1:0]) sel_price = price[i];
    sel_ok = ({1'b0, sel_idx} < N_ITEMS_L) && (sum_q >= sel_price);
  end

  // next state and registered outputs
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    vend_valid_d = vend_valid_q;
    vend_idx_d   = vend_idx_q;
    pend_d       = pend_q;
    chg_pulse_d  = 1'b0;
    chg_type_d   = 1'b0;
    coin_rej_d   = 1'b0;
    sel_rej_d    = 1'b0;

    // any coin that is not actually banked goes straight back
    if (insert && !(accepting && coin_ok)) coin_rej_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (insert && accepting && coin_ok) begin
          sum_d   = sum_add[SUM_W-1:0];
          state_d = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (!power || cancel) begin
          state_d = (sum_q != '0) ? S_REFUND : S_IDLE;
        end else if (insert) begin
          if (coin_ok) sum_d = sum_add[SUM_W-1:0];
        end else if (sel_valid) begin
          if (sel_ok) begin
            sum_d        = sum_q - sel_price;
            vend_idx_d   = sel_idx;
            vend_valid_d = 1'b1;
            state_d      = S_VEND;
          end else begin
            sel_rej_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        // losing power mid-vend behaves like a cancel once the tray clears
        if (cancel || !power) pend_d = 1'b1;
        if (take_ack) begin
          vend_valid_d = 1'b0;
          pend_d       = 1'b0;
          if ((pend_q || cancel || !power) && (sum_q != '0)) state_d = S_REFUND;
          else if (sum_q == '0)                              state_d = S_IDLE;
          else                                               state_d = S_CREDIT;
        end
      end
      S_REFUND: begin
        if (sum_q == '0) begin
          state_d = S_IDLE;
        end else if (chg_ready) begin
          chg_pulse_d = 1'b1;
          if (sum_q >= SUM_W'(2)) begin
            chg_type_d = 1'b1;
            sum_d      = sum_q - SUM_W'(2);
          end else begin
            sum_d      = sum_q - SUM_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sum_q        <= '0;
      vend_valid_q <= 1'b0;
      vend_idx_q   <= '0;
      pend_q       <= 1'b0;
      chg_pulse_q  <= 1'b0;
      chg_type_q   <= 1'b0;
      coin_rej_q   <= 1'b0;
      sel_rej_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      vend_valid_q <= vend_valid_d;
      vend_idx_q   <= vend_idx_d;
      pend_q       <= pend_d;
      chg_pulse_q  <= chg_pulse_d;
      chg_type_q   <= chg_type_d;
      coin_rej_q   <= coin_rej_d;
      sel_rej_q    <= sel_rej_d;
    end
  end

  assign hold_ind    = (state_q != S_IDLE);
  assign vend_valid  = vend_valid_q;
  assign vend_idx    = vend_idx_q;
  assign chg_pulse   = chg_pulse_q;
  assign chg_type    = chg_type_q;
  assign coin_reject = coin_rej_q;
  assign sel_reject  = sel_rej_q;
  assign coin_sum    = sum_q;

endmodule
